sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It generalises the async FIFO block under test to a synchronous variant with configurable width and depth. It adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It is used inside one clock domain as a rate buffer, and it will be reused by the existing read/write agents for verification.

Parameters:
DATA_W, 8, width of each data word in bits
DEPTH, 16, number of entries; power of two, minimum 4
AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read (pop) request
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds a popped word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was rejected
clr_err  in  1  clears overflow and underflow

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1, all of the following take their reset values on the next edge:
  - count=0, empty=1, full=0, almost_empty=1, almost_full=0
  - rd_valid=0, rd_data=0, overflow=0, underflow=0
  - wr_ptr=0, rd_ptr=0
- Storage array is not reset. Reset mid-operation discards all contents; requests in the reset cycle are ignored.
- Accepted write (wr_acc) = wr_en & (~full | rd_acc). Accepted read (rd_acc) = rd_en & ~empty.
- A write when full is accepted only if a read is accepted in the same cycle; count then stays DEPTH.
- A read when empty is always rejected. There is no write-to-read bypass, even with a simultaneous write.
- Pointers are $clog2(DEPTH) bits wide and wrap DEPTH-1 -> 0 naturally.
- count_next = count + wr_acc - rd_acc. count, full, empty, almost_full and almost_empty are all registered from count_next, so every flag is consistent with count in the same cycle.
- Read latency (default mode):
  - rd_acc in cycle N -> rd_data = mem[rd_ptr] and rd_valid=1 in cycle N+1.
  - rd_valid=0 in any cycle following a non-accepted read; rd_data holds its previous value.
- Write latency: a word written in cycle N is readable (empty deasserts) in cycle N+1.
- Error flags:
  - overflow sets when wr_en & full & ~rd_acc.
  - underflow sets when rd_en & empty.
  - Both flags hold until clr_err or rst. If a set event and clr_err occur in the same cycle, set wins.
- Parameter checks: elaboration-time assertion that DEPTH is a power of two and that both thresholds are in their legal ranges.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - rd_data continuously presents the head word whenever ~empty; rd_valid = ~empty.
  - rd_en acts as a pop/acknowledge; the next word appears in the following cycle.
  - A word written into an empty FIFO appears on rd_data one cycle after the write.
  - Underflow rule is unchanged.
- Undefined: standard one-cycle registered read as described above. The port list is identical in both builds.

Decomposition:
- sync_fifo_pkg holds: the ptr_w/cnt_w width helper function ($clog2-based), a typedef for the count type, and default threshold constants.
- One sub-module, sync_fifo_mem: simple dual-port RAM with DATA_W x DEPTH storage, one write port, and one read port that is registered (or combinational under FWFT).
- Pointer/count/flag control stays in the top module.

Test Plan (DEPTH=16, DATA_W=8, AF_THRESH=12, AE_THRESH=2):
- Fill: write 0x00..0x0F back-to-back from reset. Required: almost_empty drops after the 3rd write; almost_full rises after the 12th write; full=1 and count=16 after the 16th write.
- Overflow: while full, write 0xAA without a read. Required: overflow=1, count stays 16, and 0xAA is never read out. Then pulse clr_err. Required: overflow=0.
- Simultaneous read and write at full: Required: both are accepted, count stays 16, and ordering is preserved (0x00 is read, then 0x01 ...).
- Drain and wrap: push 40 incrementing words with interleaved reads. Required: output sequence is exactly 0..39, rd_valid occurs one cycle after each rd_acc, and empty=1 at the end.
- Underflow: rd_en while empty, with wr_en=1 in the same cycle. Required: underflow=1, rd_valid=0 next cycle, and count=1.
- Reset mid-operation: assert rst with count=9. Required: next cycle count=0, empty=1, flags cleared, and old data is never output.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: width helpers, count type and default thresholds shared by the sync FIFO.
package sync_fifo_pkg;
  typedef int unsigned cnt_t;
  localparam int   DEF_DEPTH     = 16;
  localparam cnt_t DEF_AE_THRESH = 2;
  localparam int   DEF_AF_MARGIN = 4;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DATA_W x DEPTH dual-port RAM; registered read port, combinational under SYNC_FIFO_FWFT_EN.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  logic [DATA_W-1:0] rdata_q, rdata_d;
  // reads sample the pre-write contents, so a full-FIFO read/write pair returns the oldest word
  always_comb rdata_d = rst ? '0 : re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk) rdata_q <= rdata_d;
  assign rdata = rdata_q;
`endif
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param import sync_fifo_pkg::*; #(
  parameter int   DATA_W    = 8,
  parameter int   DEPTH     = DEF_DEPTH,
  parameter cnt_t AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter cnt_t AE_THRESH = DEF_AE_THRESH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4) begin : g_depth_chk
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > cnt_t'(DEPTH)) begin : g_af_chk
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH > cnt_t'(DEPTH - 1)) begin : g_ae_chk
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          wr_acc, rd_acc;
  // all flags derive from count_d so they always agree with the registered count
  always_comb begin
    rd_acc   = rd_en & ~empty_q;
    wr_acc   = wr_en & (~full_q | rd_acc);
    count_d  = rst ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
    wr_ptr_d = rst ? '0 : wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rst ? '0 : rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    full_d   = count_d == CW'(DEPTH);
    empty_d  = count_d == '0;
    af_d     = count_d >= CW'(AF_THRESH);
    ae_d     = count_d <= CW'(AE_THRESH);
    ovf_d    = rst ? 1'b0 : (wr_en & full_q & ~rd_acc) ? 1'b1 : clr_err ? 1'b0 : ovf_q;
    unf_d    = rst ? 1'b0 : (rd_en & empty_q) ? 1'b1 : clr_err ? 1'b0 : unf_q;
  end
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    full_q   <= full_d;
    empty_q  <= empty_d;
    af_q     <= af_d;
    ae_q     <= ae_d;
    ovf_q    <= ovf_d;
    unf_q    <= unf_d;
  end
  sync_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );
`ifdef SYNC_FIFO_FWFT_EN
  assign rd_valid = ~empty_q;
`else
  logic rd_valid_q, rd_valid_d;
  always_comb rd_valid_d = ~rst & rd_acc;
  always_ff @(posedge clk) rd_valid_q <= rd_valid_d;
  assign rd_valid = rd_valid_q;
`endif
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model scoreboard plus directed literal checks for sync_fifo_param.
module tb_sync_fifo_param;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mq[$];
  logic [7:0] seen[$];
  bit         armed = 1'b0;
  bit         exp_ovf, exp_unf, exp_valid;
  logic [7:0] exp_data;

  sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit racc, wacc;
    if (rst) begin
      mq.delete();
      exp_ovf = 0; exp_unf = 0; exp_valid = 0; exp_data = 8'h00; armed = 1;
    end else if (armed) begin
      racc = rd_en && mq.size() != 0;
      wacc = wr_en && (mq.size() < DEPTH || racc);
      exp_ovf = (wr_en && mq.size() == DEPTH && !racc) ? 1'b1 : clr_err ? 1'b0 : exp_ovf;
      exp_unf = (rd_en && mq.size() == 0) ? 1'b1 : clr_err ? 1'b0 : exp_unf;
      exp_valid = racc;
      if (racc) exp_data = mq.pop_front();
      if (wacc) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("almost_full", almost_full, mq.size() >= AF);
      chk("almost_empty", almost_empty, mq.size() <= AE);
      chk("overflow", overflow, exp_ovf);
      chk("underflow", underflow, exp_unf);
`ifdef SYNC_FIFO_FWFT_EN
      chk("rd_valid", rd_valid, mq.size() != 0);
      if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
      if (rd_valid && rd_en) seen.push_back(rd_data);
`else
      chk("rd_valid", rd_valid, exp_valid);
      chk("rd_data", rd_data, exp_data);
      if (rd_valid) seen.push_back(rd_data);
`endif
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit rs, input bit c);
    wr_en = w; wr_data = d; rd_en = r; rst = rs; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = 8'h00;
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_data", rd_data, FWFT ? rd_data : 8'h00);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 8'(k - 1), 0, 0, 0);
      if (k == 2)  chk("ae_after_2", almost_empty, 1);
      if (k == 3)  chk("ae_after_3", almost_empty, 0);
      if (k == 11) chk("af_after_11", almost_full, 0);
      if (k == 12) chk("af_after_12", almost_full, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    cyc(1, 8'hAA, 0, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    cyc(0, 8'h00, 0, 0, 1);
    chk("ovf_clr", overflow, 0);
    seen.delete();
    cyc(1, 8'h10, 1, 0, 0);
    chk("rw_full_count0", count, 16);
    cyc(1, 8'h11, 1, 0, 0);
    chk("rw_full_count1", count, 16);
    for (int k = 0; k < 16; k++) cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("drain_len", seen.size(), 18);
    for (int i = 0; i < 18 && i < seen.size(); i++) chk("drain_order", seen[i], i);
    chk("drain_empty", empty, 1);
    seen.delete();
    for (int i = 0; i < 40; i++) cyc(1, 8'(i), (i % 3) != 0, 0, 0);
    for (int k = 0; k < 40 && mq.size() != 0; k++) cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("wrap_len", seen.size(), 40);
    for (int i = 0; i < 40 && i < seen.size(); i++) chk("wrap_order", seen[i], i);
    chk("wrap_empty", empty, 1);
    cyc(1, 8'h55, 1, 0, 0);
    chk("uf_set", underflow, 1);
    chk("uf_count", count, 1);
    chk("uf_rd_valid", rd_valid, FWFT);
    cyc(0, 8'h00, 0, 0, 1);
    chk("uf_clr", underflow, 0);
    for (int k = 0; k < 8; k++) cyc(1, 8'(8'h60 + k), 0, 0, 0);
    chk("pre_rst_count", count, 9);
    seen.delete();
    cyc(1, 8'hEE, 1, 1, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_almost_empty", almost_empty, 1);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_underflow", underflow, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    for (int k = 0; k < 3; k++) cyc(0, 8'h00, 1, 0, 0);
    cyc(1, 8'h77, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("post_rst_len", seen.size(), 1);
    if (seen.size() != 0) chk("post_rst_word", seen[0], 8'h77);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
